// File: rtl/regfile_pkg.sv
// Shared definitions for the decode-stage register file and its scoreboard.
// Default widths, architectural register names and the register index type.
package regfile_pkg;

  localparam int DEF_ADDRESS_WIDTH = 5;
  localparam int DEF_DATA_WIDTH    = 32;
  localparam int DEF_NUM_RD        = 2;
  localparam int DEF_CNT_WIDTH     = 2;

  localparam int REG_ZERO = 0;
  localparam int REG_A0   = 10;

  typedef logic [DEF_ADDRESS_WIDTH-1:0] reg_idx_t;

endpackage

// File: rtl/regfile_pend_ctr.sv
// Pending-write counter for one register: counts issued, unwritten results.
// Ports: clk, rst_n, inc, dec, clr in; cnt, is_max, is_one, is_zero out.
module regfile_pend_ctr #(
  parameter int CNT_WIDTH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 inc,
  input  logic                 dec,
  input  logic                 clr,
  output logic [CNT_WIDTH-1:0] cnt,
  output logic                 is_max,
  output logic                 is_one,
  output logic                 is_zero
);

  assign is_max  = (cnt == '1);
  assign is_one  = (cnt == CNT_WIDTH'(1));
  assign is_zero = (cnt == '0);

  // Guards on the edges keep the count from wrapping even if a caller
  // ignores is_max / is_zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !dec && !is_max) begin
      cnt <= cnt + CNT_WIDTH'(1);
    end else if (dec && !inc && !is_zero) begin
      cnt <= cnt - CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Decode register file: NUM_RD comb read ports with write bypass, x0 = 0,
// per-register pending-write scoreboard. Ports: rd_addr/rd_data/rd_busy,
// wr_en/wr_addr/wr_data, iss_en/iss_addr/iss_ready, flush, tap_data.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int NUM_RD        = DEF_NUM_RD,
  parameter int CNT_WIDTH     = DEF_CNT_WIDTH,
  parameter int TAP_REG       = REG_A0
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_RD*ADDRESS_WIDTH-1:0] rd_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0]    rd_data,
  output logic [NUM_RD-1:0]               rd_busy,
  input  logic                            wr_en,
  input  logic [ADDRESS_WIDTH-1:0]        wr_addr,
  input  logic [DATA_WIDTH-1:0]           wr_data,
  input  logic                            iss_en,
  input  logic [ADDRESS_WIDTH-1:0]        iss_addr,
  output logic                            iss_ready,
  input  logic                            flush,
  output logic [DATA_WIDTH-1:0]           tap_data
);

  localparam int NREG = 2 ** ADDRESS_WIDTH;
  localparam logic [ADDRESS_WIDTH-1:0] TAP_IDX =
    ADDRESS_WIDTH'(TAP_REG);

  logic [DATA_WIDTH-1:0] regs [NREG];
  logic [CNT_WIDTH-1:0]  pend [NREG];
  logic [NREG-1:0]       is_max;
  logic [NREG-1:0]       is_one;
  logic [NREG-1:0]       is_zero;

  // Storage. x0 is never written so it reads back zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) begin
        regs[r] <= '0;
      end
    end else if (wr_en && (wr_addr != '0)) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // A write to a full register frees a slot in the same cycle, so the
  // issue can be taken while the count simply holds.
  assign iss_ready = (iss_addr == '0)
                  || !is_max[iss_addr]
                  || (wr_en && (wr_addr == iss_addr));

  assign pend[0]    = '0;
  assign is_max[0]  = 1'b0;
  assign is_one[0]  = 1'b0;
  assign is_zero[0] = 1'b1;

  for (genvar r = 1; r < NREG; r++) begin : g_pend
    logic inc;
    logic dec;

    assign inc = iss_en && iss_ready
              && (iss_addr == ADDRESS_WIDTH'(r));
    assign dec = wr_en && (wr_addr == ADDRESS_WIDTH'(r))
              && (pend[r] != '0);

    regfile_pend_ctr #(
      .CNT_WIDTH (CNT_WIDTH)
    ) u_ctr (
      .clk     (clk),
      .rst_n   (rst_n),
      .inc     (inc),
      .dec     (dec),
      .clr     (flush),
      .cnt     (pend[r]),
      .is_max  (is_max[r]),
      .is_one  (is_one[r]),
      .is_zero (is_zero[r])
    );
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDRESS_WIDTH-1:0] a;
    logic                     hit;

    assign a   = rd_addr[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    assign hit = wr_en && (wr_addr == a);

    assign rd_data[i*DATA_WIDTH +: DATA_WIDTH] =
      (a == '0) ? '0      :
      hit       ? wr_data :
                  regs[a];

    // The final outstanding write landing now is covered by bypass.
    assign rd_busy[i] = (a != '0) && !is_zero[a]
                     && !(is_one[a] && hit);
  end

  assign tap_data =
    (TAP_IDX == '0)                   ? '0      :
    (wr_en && (wr_addr == TAP_IDX))   ? wr_data :
                                        regs[TAP_IDX];

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed scoreboard bench for regfile_scoreboard (NUM_RD=3, CNT_WIDTH=2).
// Expectations are queued when inputs are driven and checked at negedge.
module tb_regfile_scoreboard;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 3;

  typedef enum int {
    S_RD0, S_RD1, S_RD2, S_BUSY, S_READY, S_TAP
  } sel_e;

  typedef struct {
    sel_e        sel;
    string       tag;
    logic [31:0] val;
  } exp_t;

  logic           clk;
  logic           rst_n;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0]  rd_busy;
  logic           wr_en;
  logic [AW-1:0]  wr_addr;
  logic [DW-1:0]  wr_data;
  logic           iss_en;
  logic [AW-1:0]  iss_addr;
  logic           iss_ready;
  logic           flush;
  logic [DW-1:0]  tap_data;

  exp_t q[$];
  int   checks;
  int   errors;

  regfile_scoreboard #(
    .ADDRESS_WIDTH (AW),
    .DATA_WIDTH    (DW),
    .NUM_RD        (NR),
    .CNT_WIDTH     (2),
    .TAP_REG       (10)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_busy   (rd_busy),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .iss_en    (iss_en),
    .iss_addr  (iss_addr),
    .iss_ready (iss_ready),
    .flush     (flush),
    .tap_data  (tap_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    iss_en   = 1'b0;
    iss_addr = '0;
    flush    = 1'b0;
    rd_addr  = '0;
  endtask

  task automatic set_rd(input int p, input int a);
    rd_addr[p*AW +: AW] = AW'(a);
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    wr_en   = 1'b1;
    wr_addr = AW'(a);
    wr_data = d;
  endtask

  task automatic iss(input int a);
    iss_en   = 1'b1;
    iss_addr = AW'(a);
  endtask

  task automatic expect_v(input sel_e s, input string t,
                          input logic [31:0] v);
    exp_t e;
    e.sel = s;
    e.tag = t;
    e.val = v;
    q.push_back(e);
  endtask

  task automatic check_all();
    exp_t        e;
    logic [31:0] obs;
    while (q.size() > 0) begin
      e = q.pop_front();
      case (e.sel)
        S_RD0:   obs = rd_data[0*DW +: DW];
        S_RD1:   obs = rd_data[1*DW +: DW];
        S_RD2:   obs = rd_data[2*DW +: DW];
        S_BUSY:  obs = 32'(rd_busy);
        S_READY: obs = 32'(iss_ready);
        default: obs = tap_data;
      endcase
      checks++;
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h",
               e.tag, obs, e.val);
      end
    end
  endtask

  // Sample mid-cycle, then advance past the next edge.
  task automatic step();
    @(negedge clk);
    check_all();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    idle();
    @(posedge clk);
    #1;
    step();

    // 1 reset
    rst_n = 1'b1;
    wr(5, 32'hDEAD);
    iss(6);
    set_rd(0, 5);
    expect_v(S_RD0, "pre_rst_bypass", 32'hDEAD);
    step();
    idle();
    set_rd(0, 5);
    set_rd(1, 6);
    expect_v(S_RD0, "pre_rst_x5", 32'hDEAD);
    expect_v(S_BUSY, "pre_rst_busy", 32'h2);
    step();
    rst_n = 1'b0;
    idle();
    wr(5, 32'hBEEF);
    step();
    rst_n = 1'b1;
    idle();
    set_rd(0, 5);
    set_rd(1, 6);
    iss_addr = AW'(6);
    expect_v(S_RD0, "rst_rd0", 32'h0);
    expect_v(S_RD1, "rst_rd1", 32'h0);
    expect_v(S_BUSY, "rst_busy", 32'h0);
    expect_v(S_READY, "rst_ready", 32'h1);
    expect_v(S_TAP, "rst_tap", 32'h0);
    step();

    // 2 bypass and x0
    idle();
    wr(3, 32'h1234);
    set_rd(0, 3);
    expect_v(S_RD0, "bypass_x3", 32'h1234);
    step();
    idle();
    wr(0, 32'hFF);
    expect_v(S_RD0, "x0_bypass", 32'h0);
    expect_v(S_RD1, "x0_rd1", 32'h0);
    step();
    idle();
    set_rd(0, 3);
    expect_v(S_RD0, "x3_stored", 32'h1234);
    expect_v(S_RD1, "x0_stored", 32'h0);
    step();

    // 3 scoreboard on x7
    idle();
    iss(7);
    set_rd(0, 7);
    expect_v(S_BUSY, "iss1_busy", 32'h0);
    expect_v(S_READY, "iss1_ready", 32'h1);
    step();
    idle();
    iss(7);
    set_rd(0, 7);
    expect_v(S_BUSY, "iss2_busy", 32'h1);
    step();
    idle();
    wr(7, 32'h111);
    set_rd(0, 7);
    expect_v(S_BUSY, "wr1_busy", 32'h1);
    expect_v(S_RD0, "wr1_data", 32'h111);
    step();
    idle();
    wr(7, 32'h222);
    set_rd(0, 7);
    expect_v(S_BUSY, "wr2_busy", 32'h0);
    expect_v(S_RD0, "wr2_data", 32'h222);
    step();
    idle();
    set_rd(0, 7);
    expect_v(S_BUSY, "x7_idle_busy", 32'h0);
    expect_v(S_RD0, "x7_idle_data", 32'h222);
    step();

    // 4 saturation on x9
    for (int k = 0; k < 3; k++) begin
      idle();
      iss(9);
      expect_v(S_READY, $sformatf("sat_iss%0d", k), 32'h1);
      step();
    end
    idle();
    iss_addr = AW'(9);
    set_rd(0, 9);
    expect_v(S_READY, "sat_full", 32'h0);
    expect_v(S_BUSY, "sat_busy", 32'h1);
    step();
    idle();
    iss(9);
    expect_v(S_READY, "sat_4th", 32'h0);
    step();
    idle();
    iss(9);
    wr(9, 32'h99);
    set_rd(0, 9);
    expect_v(S_READY, "sat_iss_wr", 32'h1);
    expect_v(S_BUSY, "sat_iss_wr_busy", 32'h1);
    step();
    idle();
    iss_addr = AW'(9);
    expect_v(S_READY, "sat_hold", 32'h0);
    step();
    for (int k = 0; k < 4; k++) begin
      idle();
      wr(9, 32'hA0 + 32'(k));
      set_rd(0, 9);
      expect_v(S_BUSY, $sformatf("drain%0d_busy", k),
               (k < 2) ? 32'h1 : 32'h0);
      step();
    end
    idle();
    iss_addr = AW'(9);
    set_rd(0, 9);
    expect_v(S_BUSY, "no_uflow_busy", 32'h0);
    expect_v(S_READY, "no_uflow_ready", 32'h1);
    expect_v(S_RD0, "drain_data", 32'hA3);
    step();

    // 5 flush on x4
    idle();
    iss(4);
    step();
    idle();
    iss(4);
    step();
    idle();
    set_rd(0, 4);
    expect_v(S_BUSY, "pre_flush_busy", 32'h1);
    step();
    idle();
    flush = 1'b1;
    iss(4);
    wr(4, 32'h55);
    set_rd(0, 4);
    expect_v(S_RD0, "flush_bypass", 32'h55);
    step();
    idle();
    set_rd(0, 4);
    expect_v(S_BUSY, "post_flush_busy", 32'h0);
    expect_v(S_RD0, "post_flush_x4", 32'h55);
    step();

    // 6 three ports and tap on x10
    idle();
    wr(10, 32'hA5);
    for (int p = 0; p < NR; p++) set_rd(p, 10);
    expect_v(S_RD0, "a0_byp_rd0", 32'hA5);
    expect_v(S_RD1, "a0_byp_rd1", 32'hA5);
    expect_v(S_RD2, "a0_byp_rd2", 32'hA5);
    expect_v(S_TAP, "a0_byp_tap", 32'hA5);
    step();
    idle();
    wr(10, 32'h5A);
    for (int p = 0; p < NR; p++) set_rd(p, 10);
    expect_v(S_RD2, "a0_byp2_rd2", 32'h5A);
    expect_v(S_TAP, "a0_byp2_tap", 32'h5A);
    step();
    idle();
    for (int p = 0; p < NR; p++) set_rd(p, 10);
    expect_v(S_RD0, "a0_rd0", 32'h5A);
    expect_v(S_RD1, "a0_rd1", 32'h5A);
    expect_v(S_RD2, "a0_rd2", 32'h5A);
    expect_v(S_TAP, "a0_tap", 32'h5A);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
